// File: rtl/inst_fetch_unit.sv
// PC/fetch stage feeding a combinational-read instruction memory, with an IF/ID output register.
// Optional 16-bit instruction support is enabled by defining COMPRESSED_INST_EN.
module inst_fetch_unit #(
    parameter int unsigned INST_WIDTH                = 32,
    parameter int unsigned INST_MEMORY_ADDRESS_WIDTH = 16,
    parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned COUNT_WIDTH               = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] inst_add,
    input  logic [INST_WIDTH-1:0]                inst_data,
    input  logic                                 redirect_valid,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INST_WIDTH-1:0]                out_inst,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] out_pc,
    output logic                                 out_compressed,
    output logic                                 fault,
    output logic [COUNT_WIDTH-1:0]               fetch_count
);

    localparam int unsigned AW = INST_MEMORY_ADDRESS_WIDTH;
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    typedef enum logic {FETCH, FAULT} state_t;

    state_t                  state, state_n;
    logic [AW-1:0]           pc, pc_n;
    logic                    out_valid_n;
    logic [INST_WIDTH-1:0]   out_inst_n;
    logic [AW-1:0]           out_pc_n;
    logic                    out_compressed_n;
    logic                    fault_n;
    logic [COUNT_WIDTH-1:0]  fetch_count_n;
    logic                    capture;
    logic                    is_comp;
    logic                    straddle;
    logic                    redir_misaligned;

    // Instruction-size decode and alignment legality
`ifdef COMPRESSED_INST_EN
    assign is_comp          = (inst_data[1:0] != 2'b11);
    assign straddle         = pc[1] && !is_comp;
    assign redir_misaligned = redirect_pc[0];
`else
    assign is_comp          = 1'b0;
    assign straddle         = 1'b0;
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`endif

    assign capture  = !out_valid || out_ready;
    assign inst_add = pc;

    // Next-state and next-output logic
    always_comb begin
        state_n          = state;
        pc_n             = pc;
        out_valid_n      = out_valid;
        out_inst_n       = out_inst;
        out_pc_n         = out_pc;
        out_compressed_n = out_compressed;
        fault_n          = fault;
        fetch_count_n    = fetch_count;

        // A handshake completes even when a redirect flushes the stage
        if (out_valid && out_ready) begin
            fetch_count_n = fetch_count + COUNT_WIDTH'(1);
        end

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    if (redir_misaligned) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (capture) begin
                    if (straddle) begin
                        state_n     = FAULT;
                        fault_n     = 1'b1;
                        out_valid_n = 1'b0;
                    end else begin
                        out_inst_n       = is_comp ? INST_WIDTH'(inst_data[15:0]) : inst_data;
                        out_pc_n         = pc;
                        out_valid_n      = 1'b1;
                        out_compressed_n = is_comp;
                        pc_n             = pc + (is_comp ? AW'(2) : AW'(4));
                    end
                end
            end
            FAULT: begin
                out_valid_n = 1'b0;
                if (redirect_valid && !redir_misaligned) begin
                    pc_n    = redirect_pc;
                    fault_n = 1'b0;
                    state_n = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            out_valid      <= 1'b0;
            out_inst       <= NOP;
            out_pc         <= '0;
            out_compressed <= 1'b0;
            fault          <= 1'b0;
            fetch_count    <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            out_valid      <= out_valid_n;
            out_inst       <= out_inst_n;
            out_pc         <= out_pc_n;
            out_compressed <= out_compressed_n;
            fault          <= fault_n;
            fetch_count    <= fetch_count_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, corner sequences,
// and a randomized run checked against an instruction-stream scoreboard.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_add;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_pc;
    logic        out_compressed;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:65535];

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .inst_add       (inst_add),
        .inst_data      (inst_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_compressed (out_compressed),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign inst_data = mem[inst_add];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_inst"},  out_inst, 32'h0000_0013);
        check({tag, "_pc"},    32'(out_pc), 32'h0);
        check({tag, "_add"},   32'(inst_add), 32'h0);
        check({tag, "_comp"},  32'(out_compressed), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_count"}, fetch_count, 32'h0);
    endtask

    typedef struct {
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_add;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [18];

    // Scoreboard state for the randomized run
    logic [15:0] exp_addr, sv_pc, sv_add, nxt, tgt;
    logic [31:0] sv_inst, cnt_m;
    bit          flt_m, flush_m, stall_m, hold_add, first, mis;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = 16'(a);
            mem[a] = {av ^ 16'hC3A5, av[15:2], 2'b11};
        end
        mem[16'h0000] = 32'h0000_0093;
        mem[16'h0004] = 32'h0010_0113;

        //              redir rpc       rdy  valid pc        add       flt cnt
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0008, 1'b0, 32'd1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h000C, 1'b0, 32'd2};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0, 32'd2};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0, 32'd2};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0, 32'd2};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 16'h0010, 1'b0, 32'd3};
        tbl[7]  = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 16'h0040, 1'b0, 32'd4};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0044, 1'b0, 32'd4};
        tbl[9]  = '{1'b1, 16'h0041, 1'b1, 1'b0, 16'h0000, 16'h0044, 1'b1, 32'd5};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0044, 1'b1, 32'd5};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0044, 1'b1, 32'd5};
        tbl[12] = '{1'b1, 16'h0080, 1'b1, 1'b0, 16'h0000, 16'h0080, 1'b0, 32'd5};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0080, 16'h0084, 1'b0, 32'd5};
        tbl[14] = '{1'b1, 16'hFFFC, 1'b1, 1'b0, 16'h0000, 16'hFFFC, 1'b0, 32'd6};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFC, 16'h0000, 1'b0, 32'd6};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0, 32'd7};
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0004, 1'b0, 32'd7};

        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        @(negedge clk);
        check_reset_values("rst");

        // Directed vector table
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d_add", i),   32'(inst_add),  32'(tbl[i].e_add));
            check($sformatf("v%0d_fault", i), 32'(fault),     32'(tbl[i].e_fault));
            check($sformatf("v%0d_count", i), fetch_count,    tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                check($sformatf("v%0d_pc", i),   32'(out_pc), 32'(tbl[i].e_pc));
                check($sformatf("v%0d_inst", i), out_inst,    mem[tbl[i].e_pc]);
                check($sformatf("v%0d_comp", i), 32'(out_compressed), 32'h0);
            end
        end

        // Asynchronous reset in the middle of a stall, between clock edges
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);

`ifdef COMPRESSED_INST_EN
        mem[16'h0010] = 32'h0000_4501;
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        out_ready      = 1'b1;
        @(negedge clk);
        check("c_flush_valid", 32'(out_valid), 32'h0);
        check("c_flush_add",   32'(inst_add),  32'h0010);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("c_valid", 32'(out_valid),      32'h1);
        check("c_pc",    32'(out_pc),         32'h0010);
        check("c_inst",  out_inst,            32'h0000_4501);
        check("c_comp",  32'(out_compressed), 32'h1);
        check("c_add",   32'(inst_add),       32'h0012);
        @(negedge clk);
        check("c_straddle_fault", 32'(fault),     32'h1);
        check("c_straddle_valid", 32'(out_valid), 32'h0);
        check("c_straddle_count", fetch_count,    32'h1);
        mem[16'h0010] = {16'h0010 ^ 16'hC3A5, 14'h0004, 2'b11};
        rst = 1'b1;
        @(negedge clk);
`endif

        // Randomized run against the instruction-stream scoreboard
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        exp_addr = 16'h0;
        cnt_m    = 32'h0;
        flt_m    = 1'b0;
        flush_m  = 1'b0;
        stall_m  = 1'b0;
        hold_add = 1'b0;
        first    = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (!first) begin
                check("r_count", fetch_count, cnt_m);
                check("r_fault", 32'(fault), 32'(flt_m));
                check("r_valid", 32'(out_valid), 32'(!flt_m && !flush_m));
                if (out_valid) begin
                    nxt = exp_addr + 16'd4;
                    check("r_pc",   32'(out_pc),   32'(exp_addr));
                    check("r_inst", out_inst,      mem[exp_addr]);
                    check("r_add",  32'(inst_add), 32'(nxt));
                end
                if (stall_m) begin
                    check("r_stall_pc",   32'(out_pc), 32'(sv_pc));
                    check("r_stall_inst", out_inst,    sv_inst);
                end
                if (hold_add) check("r_hold_add", 32'(inst_add), 32'(sv_add));
            end
            first = 1'b0;

            out_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       tgt = 16'($urandom) | 16'h0001;
                1:       tgt = 16'hFFF0 | {12'h0, 2'($urandom_range(3)), 2'b00};
                default: tgt = {14'($urandom), 2'b00};
            endcase
            redirect_pc = tgt;
            mis = tgt[0];

            hold_add = (out_valid && !out_ready && !redirect_valid)
                     || (redirect_valid && mis) || (flt_m && !redirect_valid);
            stall_m  = out_valid && !out_ready && !redirect_valid;
            sv_pc    = out_pc;
            sv_inst  = out_inst;
            sv_add   = inst_add;
            if (out_valid && out_ready) begin
                cnt_m++;
                exp_addr = exp_addr + 16'd4;
            end
            if (redirect_valid) begin
                if (mis) flt_m = 1'b1;
                else begin
                    flt_m    = 1'b0;
                    exp_addr = tgt;
                end
            end
            flush_m = redirect_valid;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
